// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the SRAM memory controller
package mem_pkg;

  localparam int DEFAULT_DATA_MEM_BASE = 1024;
  localparam int SRAM_DW               = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } sram_state_t;

  function automatic logic is_access(input sram_state_t s);
    return (s == RD_LO) || (s == RD_HI) || (s == WR_LO) || (s == WR_HI);
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_wait_counter.sv
// rtl/sram_mem_ctrl_wait_counter.sv - loadable down-counter timing each half-access
module wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WAIT_CYCLES);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // done marks the last cycle of the current half-access
  assign done = (count == CW'(1));

endmodule

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - 32-bit MEM-stage access split into two 16-bit SRAM accesses
module sram_mem_ctrl
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES   = 2,
  parameter int SRAM_AW       = 18,
  parameter int DATA_MEM_BASE = DEFAULT_DATA_MEM_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int WW = SRAM_AW - 1;

  sram_state_t         state, next_state;
  logic [WW-1:0]       word_q, word_next;
  logic [31:0]         wdata_q, wdata_next;
  logic                accept;
  logic                cnt_done;

  logic [SRAM_AW-1:0]  addr_d;
  logic [SRAM_DW-1:0]  dq_out_d;
  logic                dq_oe_d, ce_n_d, oe_n_d, we_n_d, bytes_n_d;

  wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (next_state != state),
    .done (cnt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_en) begin
          next_state = WR_LO;
          accept     = 1'b1;
        end else if (rd_en) begin
          next_state = RD_LO;
          accept     = 1'b1;
        end
      end
      RD_LO:   if (cnt_done) next_state = RD_HI;
      RD_HI:   if (cnt_done) next_state = DONE;
      WR_LO:   if (cnt_done) next_state = WR_HI;
      WR_HI:   if (cnt_done) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    word_next  = word_q;
    wdata_next = wdata_q;
    if (accept) begin
      word_next  = WW'((address - 32'(DATA_MEM_BASE)) >> 2);
      wdata_next = write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      word_q  <= word_next;
      wdata_q <= wdata_next;
    end
  end

  // Pad outputs are decoded from the upcoming state and registered, so they
  // change only on state boundaries and stay flat across each half-access.
  always_comb begin
    addr_d    = sram_addr;
    dq_out_d  = sram_dq_out;
    dq_oe_d   = 1'b0;
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    bytes_n_d = 1'b1;
    if (is_access(next_state)) begin
      ce_n_d    = 1'b0;
      bytes_n_d = 1'b0;
    end
    unique case (next_state)
      RD_LO: begin
        addr_d = {word_next, 1'b0};
        oe_n_d = 1'b0;
      end
      RD_HI: begin
        addr_d = {word_next, 1'b1};
        oe_n_d = 1'b0;
      end
      WR_LO: begin
        addr_d   = {word_next, 1'b0};
        dq_out_d = wdata_next[15:0];
        dq_oe_d  = 1'b1;
        we_n_d   = 1'b0;
      end
      WR_HI: begin
        addr_d   = {word_next, 1'b1};
        dq_out_d = wdata_next[31:16];
        dq_oe_d  = 1'b1;
        we_n_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
    end else begin
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= dq_oe_d;
      sram_ce_n   <= ce_n_d;
      sram_oe_n   <= oe_n_d;
      sram_we_n   <= we_n_d;
      sram_ub_n   <= bytes_n_d;
      sram_lb_n   <= bytes_n_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (cnt_done && state == RD_LO) begin
      read_data[15:0] <= sram_dq_in;
    end else if (cnt_done && state == RD_HI) begin
      read_data[31:16] <= sram_dq_in;
    end
  end

  assign ready = (state == DONE) || (state == IDLE && !rd_en && !wr_en);

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - randomized self-checking bench for sram_mem_ctrl (W=2 and W=1)
module tb_sram_mem_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en      [2];
  logic        wr_en      [2];
  logic [31:0] address    [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data  [2];
  logic        ready      [2];
  logic [17:0] sram_addr  [2];
  logic [15:0] dq_out     [2];
  logic [15:0] dq_in      [2];
  logic        dq_oe      [2];
  logic        ce_n       [2];
  logic        oe_n       [2];
  logic        we_n       [2];
  logic        ub_n       [2];
  logic        lb_n       [2];

  bit   [15:0] mem   [2][256];
  logic [31:0] ref_w [2][64];
  logic [31:0] exp_rd[2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    sram_mem_ctrl #(.WAIT_CYCLES(g == 0 ? 2 : 1)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en[g]),
      .wr_en       (wr_en[g]),
      .address     (address[g]),
      .write_data  (write_data[g]),
      .read_data   (read_data[g]),
      .ready       (ready[g]),
      .sram_addr   (sram_addr[g]),
      .sram_dq_out (dq_out[g]),
      .sram_dq_in  (dq_in[g]),
      .sram_dq_oe  (dq_oe[g]),
      .sram_ce_n   (ce_n[g]),
      .sram_oe_n   (oe_n[g]),
      .sram_we_n   (we_n[g]),
      .sram_ub_n   (ub_n[g]),
      .sram_lb_n   (lb_n[g])
    );
  end

  // Asynchronous SRAM: combinational read, write on any clock with CE/WE low
  always_comb begin
    for (int d = 0; d < 2; d++) dq_in[d] = mem[d][sram_addr[d][7:0]];
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (!ce_n[d] && !we_n[d]) mem[d][sram_addr[d][7:0]] <= dq_out[d];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Caller sits just after a rising edge; the cycle entered now is cycle 0.
  task automatic access(input int d, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd);
    int  w     = (d == 0) ? 2 : 1;
    int  word  = int'((a - 32'd1024) >> 2);
    bit  rdop  = rd && !wr;
    int  lat   = -1;
    bit  bad_ctl  = 1'b0;
    bit  bad_addr = 1'b0;
    bit  bad_dq   = 1'b0;
    rd_en[d]      = rd;
    wr_en[d]      = wr;
    address[d]    = a;
    write_data[d] = wd;
    for (int c = 0; c < 20; c++) begin
      bit in_lo, in_hi, act;
      @(negedge clk);
      in_lo = (c >= 1) && (c <= w);
      in_hi = (c > w) && (c <= 2 * w);
      act   = in_lo || in_hi;
      if ({ce_n[d], oe_n[d], we_n[d], dq_oe[d], ub_n[d], lb_n[d]} !==
          {!act, !(act && rdop), !(act && wr), act && wr, !act, !act})
        bad_ctl = 1'b1;
      if (act && sram_addr[d] !== 18'(2 * word + (in_hi ? 1 : 0)))
        bad_addr = 1'b1;
      if (act && wr && dq_out[d] !== (in_lo ? wd[15:0] : wd[31:16]))
        bad_dq = 1'b1;
      if (ready[d]) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    check($sformatf("latency d%0d", d), lat, 2 * w + 1);
    check($sformatf("controls d%0d", d), 32'(bad_ctl), 0);
    check($sformatf("sram_addr d%0d", d), 32'(bad_addr), 0);
    if (wr) begin
      ref_w[d][word] = wd;
      check($sformatf("dq_out d%0d", d), 32'(bad_dq), 0);
      check($sformatf("rd unchanged d%0d", d), read_data[d], exp_rd[d]);
      @(posedge clk); #1;
      check($sformatf("mem lo d%0d", d), 32'(mem[d][2 * word]), 32'(wd[15:0]));
      check($sformatf("mem hi d%0d", d), 32'(mem[d][2 * word + 1]), 32'(wd[31:16]));
    end else begin
      exp_rd[d] = ref_w[d][word];
      check($sformatf("read_data d%0d", d), read_data[d], exp_rd[d]);
      @(posedge clk); #1;
    end
    rd_en[d] = 1'b0;
    wr_en[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd_en[d] = 0; wr_en[d] = 0; address[d] = 0; write_data[d] = 0;
      exp_rd[d] = 0;
      for (int i = 0; i < 64; i++) ref_w[d][i] = 0;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst ready", 32'(ready[d]), 1);
      check("rst read_data", read_data[d], 0);
      check("rst ctl", {26'd0, ce_n[d], oe_n[d], we_n[d], ub_n[d], lb_n[d], dq_oe[d]}, 32'h3E);
      check("rst addr/dq", {sram_addr[d], dq_out[d][13:0]}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Store then load, W=2
    access(0, 0, 1, 32'd1028, 32'hDEADBEEF);
    check("mem half 2", 32'(mem[0][2]), 32'hBEEF);
    check("mem half 3", 32'(mem[0][3]), 32'hDEAD);
    access(0, 1, 0, 32'd1028, 32'h0);
    check("load 1028", read_data[0], 32'hDEADBEEF);

    // Back-to-back loads with no gap between requests
    access(0, 0, 1, 32'd1032, 32'h12345678);
    @(negedge clk);
    check("idle ready", 32'(ready[0]), 1);
    @(posedge clk); #1;
    access(0, 1, 0, 32'd1024, 32'h0);
    access(0, 1, 0, 32'd1032, 32'h0);
    check("b2b second", read_data[0], 32'h12345678);

    // Both enables: write wins, read_data untouched
    access(0, 1, 1, 32'd1040, 32'hA5A55A5A);
    access(1, 1, 1, 32'd1044, 32'h0F0FF0F0);
    access(1, 1, 0, 32'd1044, 32'h0);
    check("w1 load", read_data[1], 32'h0F0FF0F0);

    // Randomized mix on both instances
    for (int n = 0; n < 60; n++) begin
      int d = n % 2;
      int op = $urandom_range(0, 3);
      logic [31:0] a = 32'd1024 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      logic [31:0] wd = $urandom;
      if (op == 3) begin
        @(negedge clk);
        check("nonmem ready", 32'(ready[d]), 1);
        @(posedge clk); #1;
      end else begin
        access(d, op == 0 || op == 2, op != 0, a, wd);
      end
    end

    // Reset in cycle 3 of a W=2 read (RD_HI)
    access(0, 0, 1, 32'd1100, 32'hCAFEF00D);
    rd_en[0]   = 1'b1;
    address[0] = 32'd1100;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    rd_en[0] = 1'b0;
    #1;
    check("mid rst read_data", read_data[0], 0);
    check("mid rst ce_n", 32'(ce_n[0]), 1);
    check("mid rst oe_n", 32'(oe_n[0]), 1);
    check("mid rst addr", 32'(sram_addr[0]), 0);
    check("mid rst state", 32'(gen_dut[0].u_dut.state), 32'(IDLE));
    exp_rd[0] = 0;
    exp_rd[1] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post rst ready", 32'(ready[0]), 1);
    @(posedge clk); #1;
    access(0, 1, 0, 32'd1100, 32'h0);
    check("post rst load", read_data[0], 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
